// File: rtl/prescaler_pkg.sv
// rtl/prescaler_pkg.sv - shared types and sizing helpers for the prescaler bank
package prescaler_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    // A single-channel bank still needs a one-bit select port.
    function automatic int chan_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int lock_cnt_width(input int lock_wait);
        return $clog2(lock_wait + 1);
    endfunction

endpackage

// File: rtl/prescaler_chan.sv
// rtl/prescaler_chan.sv - one divider channel with shadowed, wrap-aligned divisor updates
module prescaler_chan
    import prescaler_pkg::*;
#(
    parameter int               WIDTH       = 25,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_div,
    input  logic             wr_en,
    output logic             tick,
    output logic             square,
    output logic             pending
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] shadow;
    logic             en;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            div     <= DEFAULT_DIV;
            shadow  <= DEFAULT_DIV;
            en      <= 1'b1;
            pending <= 1'b0;
            tick    <= 1'b0;
            square  <= 1'b0;
        end else begin
            if (!run) begin
                cnt    <= '0;
                tick   <= 1'b0;
                square <= 1'b0;
            end else if (en) begin
                if (cnt == div) begin
                    cnt    <= '0;
                    tick   <= 1'b1;
                    square <= !square;
                    if (pending) begin
                        div     <= shadow;
                        pending <= 1'b0;
                    end
                end else begin
                    cnt  <= cnt + 1'b1;
                    tick <= 1'b0;
                end
            end else begin
                tick <= 1'b0;
            end

            // A write arriving on the wrap cycle lands after the wrap above,
            // so a live channel's new divisor waits for the following wrap.
            if (wr) begin
                if (!wr_en) begin
                    en      <= 1'b0;
                    div     <= wr_div;
                    cnt     <= '0;
                    square  <= 1'b0;
                    pending <= 1'b0;
                    tick    <= 1'b0;
                end else if (!en || !run) begin
                    en   <= 1'b1;
                    div  <= wr_div;
                    cnt  <= '0;
                    tick <= 1'b0;
                end else begin
                    shadow  <= wr_div;
                    pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/prescaler_bank.sv
// rtl/prescaler_bank.sv - PLL-lock gated bank of programmable clock-enable dividers
module prescaler_bank
    import prescaler_pkg::*;
#(
    parameter int                CHANNELS    = 4,
    parameter int                WIDTH       = 25,
    parameter logic [WIDTH-1:0]  DEFAULT_DIV = WIDTH'(2**24 - 1),
    parameter int                LOCK_WAIT   = 1024
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                pll_lock,
    input  logic                                cfg_valid,
    output logic                                cfg_ready,
    input  logic [chan_width(CHANNELS)-1:0]     cfg_chan,
    input  logic [WIDTH-1:0]                    cfg_div,
    input  logic                                cfg_en,
    output logic [CHANNELS-1:0]                 tick,
    output logic [CHANNELS-1:0]                 square,
    output logic                                running
);

    localparam int CW   = chan_width(CHANNELS);
    localparam int LW   = lock_cnt_width(LOCK_WAIT);
    localparam int NPAD = 1 << CW;

    state_t              state;
    logic [LW-1:0]       lock_cnt;
    logic                run_now;
    logic                accept;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] chan_wr;
    logic [NPAD-1:0]     pend_ext;

    // Gating with pll_lock lets the channels clear on the same edge that leaves RUN.
    assign run_now = (state == RUN) && pll_lock;

    // Unpopulated select codes read as not-pending, so writes to them are accepted and dropped.
    always_comb begin
        pend_ext                 = '0;
        pend_ext[CHANNELS-1:0]   = pending;
    end

    assign cfg_ready = !rst && !pend_ext[cfg_chan];
    assign accept    = cfg_valid && cfg_ready;

    always_comb begin
        chan_wr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            chan_wr[i] = accept && (cfg_chan == CW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WAIT_LOCK;
            lock_cnt <= '0;
            running  <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    lock_cnt <= '0;
                    running  <= 1'b0;
                    if (pll_lock) state <= SETTLE;
                end
                SETTLE: begin
                    if (!pll_lock) begin
                        state    <= WAIT_LOCK;
                        lock_cnt <= '0;
                    end else if (lock_cnt == LW'(LOCK_WAIT - 1)) begin
                        state    <= RUN;
                        running  <= 1'b1;
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!pll_lock) begin
                        state   <= WAIT_LOCK;
                        running <= 1'b0;
                    end
                end
                default: begin
                    state   <= WAIT_LOCK;
                    running <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        prescaler_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .run     (run_now),
            .wr      (chan_wr[i]),
            .wr_div  (cfg_div),
            .wr_en   (cfg_en),
            .tick    (tick[i]),
            .square  (square[i]),
            .pending (pending[i])
        );
    end

endmodule

// File: tb/tb_prescaler_bank.sv
// tb/tb_prescaler_bank.sv - directed bench with an event-scheduled reference model
module tb_prescaler_bank;

    localparam int               CH        = 3;
    localparam int               CW        = 2;
    localparam int               WIDTH     = 12;
    localparam int               LOCK_WAIT = 8;
    localparam logic [WIDTH-1:0] DEF       = 12'd20;

    logic             clk = 1'b0;
    logic             rst;
    logic             pll_lock;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CW-1:0]    cfg_chan;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_en;
    logic [CH-1:0]    tick;
    logic [CH-1:0]    square;
    logic             running;

    always #5 clk = ~clk;

    prescaler_bank #(
        .CHANNELS    (CH),
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEF),
        .LOCK_WAIT   (LOCK_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pll_lock  (pll_lock),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .tick      (tick),
        .square    (square),
        .running   (running)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference: lock is a streak count, each channel is an absolute next-tick time.
    int streak = 0;
    bit m_run  = 0;
    int m_period [CH];
    int m_pperiod[CH];
    int m_next   [CH];
    bit m_en     [CH];
    bit m_pend   [CH];
    bit m_tick   [CH];
    bit m_sq     [CH];

    int tick_q[CH][$];
    int rise_cyc = -1000;
    bit prev_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_ready();
        if (rst !== 1'b0) return 1'b0;
        if (int'(cfg_chan) < CH) return !m_pend[cfg_chan];
        return 1'b1;
    endfunction

    task automatic model_step();
        bit acc, run_cur, adv, next_run;
        int c;
        acc     = cfg_valid && m_ready();
        run_cur = m_run;
        adv     = run_cur && pll_lock;
        cyc++;
        if (rst) begin
            streak = 0;
            m_run  = 0;
            for (int i = 0; i < CH; i++) begin
                m_period[i] = int'(DEF) + 1;
                m_en[i]     = 1;
                m_pend[i]   = 0;
                m_tick[i]   = 0;
                m_sq[i]     = 0;
                m_next[i]   = 0;
            end
        end else begin
            streak   = pll_lock ? streak + 1 : 0;
            next_run = (streak >= LOCK_WAIT + 1);
            for (int i = 0; i < CH; i++) begin
                m_tick[i] = 0;
                if (adv && m_en[i] && cyc == m_next[i]) begin
                    m_tick[i] = 1;
                    m_sq[i]   = !m_sq[i];
                    if (m_pend[i]) begin
                        m_period[i] = m_pperiod[i];
                        m_pend[i]   = 0;
                    end
                    m_next[i] = cyc + m_period[i];
                end
            end
            if (acc && int'(cfg_chan) < CH) begin
                c = int'(cfg_chan);
                if (!cfg_en) begin
                    m_en[c]     = 0;
                    m_period[c] = int'(cfg_div) + 1;
                    m_sq[c]     = 0;
                    m_pend[c]   = 0;
                    m_tick[c]   = 0;
                end else if (!m_en[c] || !adv) begin
                    m_en[c]     = 1;
                    m_period[c] = int'(cfg_div) + 1;
                    m_tick[c]   = 0;
                    m_next[c]   = cyc + m_period[c];
                end else begin
                    m_pperiod[c] = int'(cfg_div) + 1;
                    m_pend[c]    = 1;
                end
            end
            for (int i = 0; i < CH; i++) begin
                if (!next_run) begin
                    m_tick[i] = 0;
                    m_sq[i]   = 0;
                end else if (!run_cur) begin
                    m_next[i] = cyc + m_period[i];
                end
            end
            m_run = next_run;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            check("running", running, m_run);
            for (int i = 0; i < CH; i++) begin
                check($sformatf("tick%0d", i), tick[i], m_tick[i]);
                check($sformatf("square%0d", i), square[i], m_sq[i]);
                if (tick[i] === 1'b1) tick_q[i].push_back(cyc);
            end
            if (running === 1'b1 && !prev_run) rise_cyc = cyc;
            prev_run = (running === 1'b1);
            @(negedge clk);
            #1;
            check("cfg_ready", cfg_ready, m_ready());
        end
    end

    task automatic write(input int ch, input int dv, input bit e);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_chan  = CW'(ch);
        cfg_div   = WIDTH'(dv);
        cfg_en    = e;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ticks(input int ch, input int count, input int budget);
        int b = budget;
        while (tick_q[ch].size() < count && b > 0) begin
            @(negedge clk);
            b--;
        end
        check($sformatf("tick%0d_arrived", ch), tick_q[ch].size() >= count, 1);
    endtask

    task automatic wait_running(input int budget);
        int b = budget;
        while (running !== 1'b1 && b > 0) begin
            @(negedge clk);
            b--;
        end
    endtask

    initial begin
        int rel, rise1, n, n1;
        rst       = 1'b1;
        pll_lock  = 1'b1;
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_div   = '0;
        cfg_en    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rel = cyc;

        // Programmed during SETTLE, so every write applies immediately.
        write(1, 3, 1);
        write(0, 9, 1);
        write(2, 5, 1);
        write(3, 7, 1);
        wait_running(30);
        check("lock_to_run", rise_cyc - rel, 9);
        rise1 = rise_cyc;

        wait_ticks(1, 3, 40);
        check("ch1_first_tick", tick_q[1][0] - rise1, 4);
        check("ch1_gap_a", tick_q[1][1] - tick_q[1][0], 4);
        check("ch1_gap_b", tick_q[1][2] - tick_q[1][1], 4);

        // Mid-count divisor change on ch0, then a write that lands on a wrap.
        n = tick_q[0].size();
        wait_ticks(0, n + 1, 30);
        repeat (3) @(negedge clk);
        write(0, 1, 1);
        check("ch0_ready_pending", cfg_ready, 0);
        wait_ticks(0, n + 4, 40);
        check("ch0_gap_old", tick_q[0][n + 1] - tick_q[0][n], 10);
        check("ch0_gap_new_a", tick_q[0][n + 2] - tick_q[0][n + 1], 2);
        check("ch0_gap_new_b", tick_q[0][n + 3] - tick_q[0][n + 2], 2);
        write(0, 3, 1);
        wait_ticks(0, n + 7, 40);
        check("ch0_wrapwr_a", tick_q[0][n + 4] - tick_q[0][n + 3], 2);
        check("ch0_wrapwr_b", tick_q[0][n + 5] - tick_q[0][n + 4], 2);
        check("ch0_wrapwr_c", tick_q[0][n + 6] - tick_q[0][n + 5], 4);

        write(2, 5, 0);
        check("ch2_off_tick", tick[2], 0);
        check("ch2_off_square", square[2], 0);
        write(2, 0, 1);
        repeat (5) begin
            @(negedge clk);
            check("ch2_div0_tick", tick[2], 1);
        end

        @(negedge clk);
        pll_lock = 1'b0;
        @(negedge clk);
        check("lockloss_running", running, 0);
        check("lockloss_tick", tick, 0);
        check("lockloss_square", square, 0);
        repeat (2) @(negedge clk);
        pll_lock = 1'b1;
        repeat (6) @(negedge clk);
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        rel = cyc;
        n1  = tick_q[1].size();
        wait_running(30);
        check("relock_to_run", rise_cyc - rel, 9);
        wait_ticks(1, n1 + 1, 20);
        check("ch1_relock_first", tick_q[1][n1] - rise_cyc, 4);

        repeat (20) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
